// File: rtl/reg_writeback_unit_if.sv
// Bundle of the writeback unit's datapath and handshake signals:
// ALU result input, load issue/return, decode read queries and the
// register-file write port. "master" is the pipeline/testbench side,
// "slave" is the writeback unit itself.
interface reg_writeback_unit_if;
  // ALU writeback (never back-pressured)
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  // Load issue from decode
  logic        load_issue;
  logic [4:0]  load_issue_reg;
  logic        issue_ready;
  // Load data return
  logic        load_valid;
  logic [4:0]  load_reg;
  logic [31:0] load_data;
  logic        load_ready;
  // Decode pending queries
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic        pending_a;
  logic        pending_b;
  // Register file write port
  logic [4:0]  write_reg;
  logic        write_enable;
  logic [31:0] write_data;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output load_issue, load_issue_reg,
    input  issue_ready,
    output load_valid, load_reg, load_data,
    input  load_ready,
    output read_reg1, read_reg2,
    input  pending_a, pending_b,
    input  write_reg, write_enable, write_data
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  load_issue, load_issue_reg,
    output issue_ready,
    input  load_valid, load_reg, load_data,
    output load_ready,
    input  read_reg1, read_reg2,
    output pending_a, pending_b,
    output write_reg, write_enable, write_data
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Register-file write-side initiator. Merges the in-order ALU writeback
// (always highest priority) with variable-latency load returns buffered
// in an in-order FIFO, and keeps per-register outstanding-load counters
// so decode can stall reads of registers whose load is still in flight.
// DEPTH must be a power of two in 2..16 so the FIFO pointers wrap freely.
module reg_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_enable,
  reg_writeback_unit_if.slave        bus,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]      COUNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Load FIFO storage and bookkeeping
  logic [4:0]  fifo_reg  [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  // Outstanding-load counters, one per architectural register
  logic [CNT_W-1:0] cnt [32];

  // Registered write port
  logic        wb_enable;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  // Per-cycle decisions
  logic        load_ready;
  logic        load_accept;
  logic        load_nonzero;
  logic        alu_sel;
  logic        fifo_empty;
  logic        pop;
  logic        bypass;
  logic        push;
  logic        sel_en;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;
  logic        dec;
  logic [4:0]  dec_reg;
  logic        inc;
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;

  // Handshake qualification: nothing completes while the block is frozen
  always_comb begin
    load_ready   = clk_enable && (count < DEPTH_CNT);
    load_accept  = bus.load_valid && load_ready;
    load_nonzero = (bus.load_reg != 5'd0);
    alu_sel      = bus.alu_valid && (bus.alu_reg != 5'd0);
    fifo_empty   = (count == '0);
  end

  // Write-port arbitration: ALU first, then FIFO head, then direct bypass
  always_comb begin
    sel_en   = 1'b0;
    sel_reg  = 5'd0;
    sel_data = 32'd0;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (clk_enable) begin
      if (alu_sel) begin
        sel_en   = 1'b1;
        sel_reg  = bus.alu_reg;
        sel_data = bus.alu_data;
      end else if (!fifo_empty) begin
        pop      = 1'b1;
        sel_en   = 1'b1;
        sel_reg  = fifo_reg[rd_ptr];
        sel_data = fifo_data[rd_ptr];
      end else if (load_accept && load_nonzero) begin
        bypass   = 1'b1;
        sel_en   = 1'b1;
        sel_reg  = bus.load_reg;
        sel_data = bus.load_data;
      end else begin
        sel_en   = 1'b0;
      end
    end else begin
      sel_en = 1'b0;
    end
    // Loads to $0 are swallowed; a bypassed load must not also be queued
    push = load_accept && load_nonzero && !bypass;
  end

  // Scoreboard update requests: one increment (issue) and one decrement
  // (load write selected) per cycle at most
  always_comb begin
    dec     = pop || bypass;
    dec_reg = pop ? fifo_reg[rd_ptr] : bus.load_reg;
    inc     = clk_enable && bus.load_issue &&
              (bus.load_issue_reg != 5'd0) &&
              (cnt[bus.load_issue_reg] != CNT_MAX);
    if (inc) begin
      inc_vec = 32'd1 << bus.load_issue_reg;
    end else begin
      inc_vec = 32'd0;
    end
    if (dec && (cnt[dec_reg] != '0)) begin
      dec_vec = 32'd1 << dec_reg;
    end else begin
      dec_vec = 32'd0;
    end
  end

  // FIFO pointers, occupancy and entry storage
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_reg[i]  <= 5'd0;
        fifo_data[i] <= 32'd0;
      end
    end else if (clk_enable) begin
      if (push) begin
        fifo_reg[wr_ptr]  <= bus.load_reg;
        fifo_data[wr_ptr] <= bus.load_data;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Outstanding-load counters; simultaneous inc/dec of one register cancels
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= '0;
      end
    end else if (clk_enable) begin
      for (int i = 0; i < 32; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_ONE;
          2'b01:   cnt[i] <= cnt[i] - CNT_ONE;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Registered register-file write port; holds while frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_enable <= 1'b0;
      wb_reg    <= 5'd0;
      wb_data   <= 32'd0;
    end else if (clk_enable) begin
      wb_enable <= sel_en;
      if (sel_en) begin
        wb_reg  <= sel_reg;
        wb_data <= sel_data;
      end
    end
  end

  assign bus.load_ready   = load_ready;
  assign bus.issue_ready  = clk_enable && (cnt[bus.load_issue_reg] != CNT_MAX);
  assign bus.pending_a    = (bus.read_reg1 != 5'd0) && (cnt[bus.read_reg1] != '0);
  assign bus.pending_b    = (bus.read_reg2 != 5'd0) && (cnt[bus.read_reg2] != '0);
  assign bus.write_enable = wb_enable;
  assign bus.write_reg    = wb_reg;
  assign bus.write_data   = wb_data;
  assign fifo_count       = count;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit. A negedge monitor scores every
// committed write: ALU writes must appear exactly one enabled cycle after
// being driven, every other write must be the oldest accepted load.
module tb_reg_writeback_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic       clk;
  logic       reset;
  logic       clk_enable;
  logic [2:0] fifo_count;

  int checks;
  int errors;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t  load_q[$];
  logic exp_alu_v;
  wr_t  exp_alu;

  reg_writeback_unit_if bus();

  reg_writeback_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid  = 1'b0;
    bus.load_issue = 1'b0;
    bus.load_valid = 1'b0;
  endtask

  // Scoreboard monitor: commits happen only in enabled, non-reset cycles
  initial begin
    exp_alu_v = 1'b0;
    exp_alu   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        load_q.delete();
        exp_alu_v = 1'b0;
      end else if (clk_enable) begin
        if (bus.write_enable) begin
          if (exp_alu_v) begin
            check("alu_wr_reg", {27'd0, bus.write_reg}, {27'd0, exp_alu.r});
            check("alu_wr_data", bus.write_data, exp_alu.d);
          end else if (load_q.size() == 0) begin
            check("unexpected_wr", {31'd0, bus.write_enable}, 32'd0);
          end else begin
            wr_t e;
            e = load_q.pop_front();
            check("load_wr_reg", {27'd0, bus.write_reg}, {27'd0, e.r});
            check("load_wr_data", bus.write_data, e.d);
          end
        end else if (exp_alu_v) begin
          check("alu_wr_missing", {31'd0, bus.write_enable}, 32'd1);
        end
        exp_alu_v = bus.alu_valid && (bus.alu_reg != 5'd0);
        exp_alu   = {bus.alu_reg, bus.alu_data};
        if (bus.load_valid && bus.load_ready && (bus.load_reg != 5'd0)) begin
          load_q.push_back({bus.load_reg, bus.load_data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    clk_enable = 1'b1;
    idle();
    bus.alu_reg = 5'd0;        bus.alu_data = 32'd0;
    bus.load_issue_reg = 5'd0; bus.load_reg = 5'd0;
    bus.load_data = 32'd0;     bus.read_reg1 = 5'd0;
    bus.read_reg2 = 5'd0;

    // Reset state
    repeat (2) next_cycle();
    reset = 1'b0;
    bus.read_reg1 = 5'd5;
    bus.read_reg2 = 5'd9;
    @(negedge clk);
    check("rst_we",      {31'd0, bus.write_enable}, 32'd0);
    check("rst_count",   {29'd0, fifo_count}, 32'd0);
    check("rst_pend_a",  {31'd0, bus.pending_a}, 32'd0);
    check("rst_pend_b",  {31'd0, bus.pending_b}, 32'd0);
    check("rst_lready",  {31'd0, bus.load_ready}, 32'd1);
    check("rst_iready",  {31'd0, bus.issue_ready}, 32'd1);

    // Load bypass to $5
    next_cycle(); bus.load_issue = 1'b1; bus.load_issue_reg = 5'd5;
    @(negedge clk);
    check("byp_pend_pre", {31'd0, bus.pending_a}, 32'd0);
    next_cycle(); idle();
    bus.load_valid = 1'b1; bus.load_reg = 5'd5; bus.load_data = 32'hDEADBEEF;
    @(negedge clk);
    check("byp_pend_inflight", {31'd0, bus.pending_a}, 32'd1);
    check("byp_lready", {31'd0, bus.load_ready}, 32'd1);
    next_cycle(); idle();
    @(negedge clk);
    check("byp_we",   {31'd0, bus.write_enable}, 32'd1);
    check("byp_reg",  {27'd0, bus.write_reg}, 32'd5);
    check("byp_data", bus.write_data, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("byp_pend_post", {31'd0, bus.pending_a}, 32'd0);
    check("byp_we_off",    {31'd0, bus.write_enable}, 32'd0);

    // ALU/load conflict
    next_cycle(); bus.load_issue = 1'b1; bus.load_issue_reg = 5'd7;
    next_cycle(); idle();
    bus.alu_valid = 1'b1;  bus.alu_reg = 5'd3;  bus.alu_data = 32'h11;
    bus.load_valid = 1'b1; bus.load_reg = 5'd7; bus.load_data = 32'h22;
    next_cycle(); idle();
    @(negedge clk);
    check("cfl_reg1",  {27'd0, bus.write_reg}, 32'd3);
    check("cfl_data1", bus.write_data, 32'h11);
    check("cfl_count", {29'd0, fifo_count}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("cfl_reg2",   {27'd0, bus.write_reg}, 32'd7);
    check("cfl_data2",  bus.write_data, 32'h22);
    check("cfl_count0", {29'd0, fifo_count}, 32'd0);

    // Back-pressure: ALU busy for 6 cycles while 5 loads arrive
    for (int i = 0; i < 5; i++) begin
      next_cycle(); idle();
      bus.load_issue = 1'b1; bus.load_issue_reg = 5'(10 + i);
    end
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      next_cycle(); idle();
      bus.alu_valid = 1'b1; bus.alu_reg = 5'(20 + k); bus.alu_data = 32'hA000 + 32'(k);
      bus.load_valid = 1'b1; bus.load_reg = 5'(10 + acc); bus.load_data = 32'hB000 + 32'(acc);
      @(negedge clk);
      check("bp_lready", {31'd0, bus.load_ready}, (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) acc++;
    end
    next_cycle(); idle();
    bus.load_valid = 1'b1; bus.load_reg = 5'd14; bus.load_data = 32'hB004;
    @(negedge clk);
    check("bp_full_pop_lready", {31'd0, bus.load_ready}, 32'd0);
    check("bp_full_count", {29'd0, fifo_count}, 32'd4);
    check("bp_last_alu", bus.write_data, 32'hA005);
    next_cycle();
    @(negedge clk);
    check("bp_lready_again", {31'd0, bus.load_ready}, 32'd1);
    check("bp_count3", {29'd0, fifo_count}, 32'd3);
    check("bp_drain0", bus.write_data, 32'hB000);
    for (int j = 1; j < 5; j++) begin
      next_cycle(); idle();
      @(negedge clk);
      check("bp_drain_we",   {31'd0, bus.write_enable}, 32'd1);
      check("bp_drain_data", bus.write_data, 32'hB000 + 32'(j));
      check("bp_drain_cnt",  {29'd0, fifo_count}, 32'(4 - j));
    end
    next_cycle();
    @(negedge clk);
    check("bp_idle_we", {31'd0, bus.write_enable}, 32'd0);

    // Counter saturation on $9
    bus.read_reg1 = 5'd9;
    for (int i = 0; i < 7; i++) begin
      next_cycle(); idle();
      bus.load_issue = 1'b1; bus.load_issue_reg = 5'd9;
      @(negedge clk);
      check("sat_iready_fill", {31'd0, bus.issue_ready}, 32'd1);
    end
    next_cycle(); idle(); bus.load_issue_reg = 5'd9;
    @(negedge clk);
    check("sat_iready_full", {31'd0, bus.issue_ready}, 32'd0);
    check("sat_pending",     {31'd0, bus.pending_a}, 32'd1);
    bus.load_issue_reg = 5'd8;
    #1;
    check("sat_iready_other", {31'd0, bus.issue_ready}, 32'd1);
    next_cycle(); idle(); bus.load_issue_reg = 5'd9;
    bus.load_valid = 1'b1; bus.load_reg = 5'd9; bus.load_data = 32'h99;
    @(negedge clk);
    check("sat_iready_samecyc", {31'd0, bus.issue_ready}, 32'd0);
    next_cycle(); idle();
    @(negedge clk);
    check("sat_iready_rel", {31'd0, bus.issue_ready}, 32'd1);
    check("sat_wr_reg",     {27'd0, bus.write_reg}, 32'd9);
    check("sat_pend_left",  {31'd0, bus.pending_a}, 32'd1);

    // $0 load and clk_enable freeze mid-drain
    next_cycle(); bus.load_issue = 1'b1; bus.load_issue_reg = 5'd16;
    next_cycle(); bus.load_issue_reg = 5'd17;
    next_cycle(); idle();
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd21; bus.alu_data = 32'h2100;
    bus.load_valid = 1'b1; bus.load_reg = 5'd16; bus.load_data = 32'h1600;
    next_cycle();
    bus.alu_reg = 5'd22; bus.alu_data = 32'h2200;
    bus.load_reg = 5'd17; bus.load_data = 32'h1700;
    next_cycle();
    bus.alu_reg = 5'd23; bus.alu_data = 32'h2300;
    bus.load_reg = 5'd0; bus.load_data = 32'hFFFFFFFF;
    @(negedge clk);
    check("z_lready", {31'd0, bus.load_ready}, 32'd1);
    check("z_count_pre", {29'd0, fifo_count}, 32'd2);
    next_cycle(); idle();
    @(negedge clk);
    check("z_count_post", {29'd0, fifo_count}, 32'd2);
    check("z_alu23", {27'd0, bus.write_reg}, 32'd23);
    next_cycle();
    clk_enable = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd25; bus.alu_data = 32'h2500;
    for (int f = 0; f < 3; f++) begin
      if (f > 0) next_cycle();
      @(negedge clk);
      check("frz_lready", {31'd0, bus.load_ready}, 32'd0);
      check("frz_iready", {31'd0, bus.issue_ready}, 32'd0);
      check("frz_we",     {31'd0, bus.write_enable}, 32'd1);
      check("frz_data",   bus.write_data, 32'h1600);
      check("frz_count",  {29'd0, fifo_count}, 32'd1);
    end
    next_cycle(); clk_enable = 1'b1; idle();
    @(negedge clk);
    check("res_data16", bus.write_data, 32'h1600);
    check("res_count1", {29'd0, fifo_count}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("res_data17", bus.write_data, 32'h1700);
    check("res_count0", {29'd0, fifo_count}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("res_we_off", {31'd0, bus.write_enable}, 32'd0);
    check("lq_empty", 32'(load_q.size()), 32'd0);

    // Reset with full FIFO and non-zero counters
    for (int i = 0; i < 4; i++) begin
      next_cycle(); idle();
      bus.load_issue = 1'b1; bus.load_issue_reg = 5'(24 + i);
    end
    for (int f = 0; f < 4; f++) begin
      next_cycle(); idle();
      bus.alu_valid = 1'b1; bus.alu_reg = 5'(1 + f); bus.alu_data = 32'h100 + 32'(f);
      bus.load_valid = 1'b1; bus.load_reg = 5'(24 + f); bus.load_data = 32'h2400 + 32'(f);
      @(negedge clk);
      check("mr_lready", {31'd0, bus.load_ready}, 32'd1);
    end
    next_cycle(); idle(); reset = 1'b1;
    bus.read_reg1 = 5'd24; bus.read_reg2 = 5'd9;
    @(negedge clk);
    check("mr_full",   {29'd0, fifo_count}, 32'd4);
    check("mr_pend_a", {31'd0, bus.pending_a}, 32'd1);
    check("mr_pend_b", {31'd0, bus.pending_b}, 32'd1);
    next_cycle(); reset = 1'b0;
    @(negedge clk);
    check("mr_we",     {31'd0, bus.write_enable}, 32'd0);
    check("mr_count",  {29'd0, fifo_count}, 32'd0);
    check("mr_pend_a0", {31'd0, bus.pending_a}, 32'd0);
    check("mr_pend_b0", {31'd0, bus.pending_b}, 32'd0);
    check("mr_lready", {31'd0, bus.load_ready}, 32'd1);
    check("mr_wreg",   {27'd0, bus.write_reg}, 32'd0);
    check("mr_wdata",  bus.write_data, 32'd0);
    next_cycle();
    @(negedge clk);
    check("mr_we_after", {31'd0, bus.write_enable}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
